// File: rtl/drive_led_presence_mgr.sv
// Per-drive presence debounce, presence-change event latching and LED pattern
// generation for the 36-bay baseboard drive LED/presence multiplexer.
module drive_led_presence_mgr #(
    parameter int   CLK_PER_MS   = 25000,
    parameter int   DB_CNT       = 3,
    parameter logic LED_ON_LEVEL = 1'b0
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        SAMPLE_STB,
    input  logic [35:0] PRSNT,
    input  logic [35:0] IDENT,
    input  logic        WR_EN,
    input  logic [5:0]  WR_ADDR,
    input  logic [3:0]  WR_DATA,
    input  logic [5:0]  RD_ADDR,
    output logic [7:0]  RD_DATA,
    input  logic [35:0] CHG_CLR,
    output logic [35:0] AMBER_DAT,
    output logic [35:0] BLUE_DAT,
    output logic [35:0] PRSNT_DB,
    output logic [35:0] PRSNT_CHG,
    output logic        INT
);

    localparam int NDRV = 36;
    localparam int PW   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    logic [PW-1:0]        pre_cnt;
    logic                 ms_tick;
    logic [9:0]           slow_cnt;
    logic [7:0]           fast_cnt;
    logic                 slow_on;
    logic                 fast_on;

    logic [NDRV-1:0][2:0] dbc;
    logic [NDRV-1:0][2:0] dbc_nxt;
    logic [NDRV-1:0]      db_nxt;
    logic [NDRV-1:0]      chg_set;
    logic [NDRV-1:0]      ident_q;

    logic [NDRV-1:0][1:0] amber_mode;
    logic [NDRV-1:0][1:0] blue_mode;
    logic [NDRV-1:0]      amber_lit;
    logic [NDRV-1:0]      blue_lit;

    // Shared blink timebase so every drive blinks in phase.
    assign ms_tick = (pre_cnt == PW'(CLK_PER_MS - 1));
    assign slow_on = (slow_cnt < 10'd500);
    assign fast_on = (fast_cnt < 8'd125);

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            pre_cnt  <= '0;
            slow_cnt <= '0;
            fast_cnt <= '0;
        end else if (ms_tick) begin
            pre_cnt  <= '0;
            slow_cnt <= (slow_cnt == 10'd999) ? 10'd0 : slow_cnt + 10'd1;
            fast_cnt <= (fast_cnt == 8'd249) ? 8'd0 : fast_cnt + 8'd1;
        end else begin
            pre_cnt  <= pre_cnt + PW'(1);
        end
    end

    // A flip needs DB_CNT consecutive samples that disagree with the debounced value.
    always_comb begin
        dbc_nxt = dbc;
        db_nxt  = PRSNT_DB;
        chg_set = '0;
        if (SAMPLE_STB) begin
            for (int i = 0; i < NDRV; i++) begin
                if (PRSNT[i] == PRSNT_DB[i]) begin
                    dbc_nxt[i] = 3'd0;
                end else if (dbc[i] == 3'(DB_CNT - 1)) begin
                    db_nxt[i]  = ~PRSNT_DB[i];
                    dbc_nxt[i] = 3'd0;
                    chg_set[i] = 1'b1;
                end else begin
                    dbc_nxt[i] = dbc[i] + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            dbc       <= '0;
            PRSNT_DB  <= '0;
            PRSNT_CHG <= '0;
            INT       <= 1'b0;
            ident_q   <= '0;
        end else begin
            dbc       <= dbc_nxt;
            PRSNT_DB  <= db_nxt;
            // A new event beats a simultaneous clear on the same bit.
            PRSNT_CHG <= (PRSNT_CHG & ~CHG_CLR) | chg_set;
            INT       <= |PRSNT_CHG;
            if (SAMPLE_STB) begin
                ident_q <= IDENT;
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            amber_mode <= '0;
            blue_mode  <= '0;
        end else if (WR_EN && (WR_ADDR < 6'd36)) begin
            amber_mode[WR_ADDR] <= WR_DATA[3:2];
            blue_mode[WR_ADDR]  <= WR_DATA[1:0];
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            RD_DATA <= 8'h00;
        end else if (RD_ADDR < 6'd36) begin
            RD_DATA <= {2'b00, PRSNT_DB[RD_ADDR], PRSNT_CHG[RD_ADDR],
                        amber_mode[RD_ADDR], blue_mode[RD_ADDR]};
        end else begin
            RD_DATA <= 8'h00;
        end
    end

    function automatic logic mode_lit(input logic [1:0] mode, input logic s_on,
                                      input logic f_on);
        logic res;
        case (mode)
            2'b00:   res = 1'b0;
            2'b01:   res = 1'b1;
            2'b10:   res = s_on;
            default: res = f_on;
        endcase
        return res;
    endfunction

    // Absent drives stay dark; identify requests override the blue mode.
    always_comb begin
        amber_lit = '0;
        blue_lit  = '0;
        for (int i = 0; i < NDRV; i++) begin
            amber_lit[i] = PRSNT_DB[i] & mode_lit(amber_mode[i], slow_on, fast_on);
            blue_lit[i]  = PRSNT_DB[i] & (ident_q[i] ? fast_on
                                          : mode_lit(blue_mode[i], slow_on, fast_on));
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            AMBER_DAT <= {NDRV{~LED_ON_LEVEL}};
            BLUE_DAT  <= {NDRV{~LED_ON_LEVEL}};
        end else begin
            AMBER_DAT <= amber_lit ^ {NDRV{~LED_ON_LEVEL}};
            BLUE_DAT  <= blue_lit ^ {NDRV{~LED_ON_LEVEL}};
        end
    end

endmodule

// File: tb/tb_drive_led_presence_mgr.sv
// Bench for drive_led_presence_mgr: directed scenarios plus randomized traffic,
// checked against a millisecond-level behavioural model of the drive bay.
module tb_drive_led_presence_mgr;

    localparam int   CPM = 4;
    localparam int   DBN = 3;
    localparam logic ON  = 1'b0;
    localparam int   ND  = 36;
    localparam logic [35:0] ALL1 = {36{1'b1}};
    localparam logic [35:0] OFFV = {36{~ON}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic [35:0] prsnt = '0;
    logic [35:0] ident = '0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic [5:0]  rd_addr = '0;
    logic [35:0] chg_clr = '0;
    logic [7:0]  rd_data;
    logic [35:0] amber_dat, blue_dat, prsnt_db, prsnt_chg;
    logic        irq;

    drive_led_presence_mgr #(.CLK_PER_MS(CPM), .DB_CNT(DBN), .LED_ON_LEVEL(ON)) dut (
        .SYSCLK(clk), .RESET(rst), .SAMPLE_STB(stb), .PRSNT(prsnt), .IDENT(ident),
        .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .RD_ADDR(rd_addr),
        .RD_DATA(rd_data), .CHG_CLR(chg_clr), .AMBER_DAT(amber_dat), .BLUE_DAT(blue_dat),
        .PRSNT_DB(prsnt_db), .PRSNT_CHG(prsnt_chg), .INT(irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: drive-level state plus elapsed milliseconds since reset.
    logic [35:0] m_db, m_chg, m_ident;
    int          m_run [ND];
    logic [1:0]  m_amb [ND];
    logic [1:0]  m_blu [ND];
    int          m_edges;
    logic [35:0] e_amber, e_blue;
    logic        e_int;
    logic [7:0]  e_rd;

    function automatic logic lit(input logic [1:0] mode, input int ms);
        case (mode)
            2'd0:    return 1'b0;
            2'd1:    return 1'b1;
            2'd2:    return (ms % 1000) < 500;
            default: return (ms % 250) < 125;
        endcase
    endfunction

    function automatic logic [35:0] rand36();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[35:0];
    endfunction

    // Advance one clock: outputs registered at this edge come from pre-edge state.
    task automatic step();
        int ms;
        int a;
        logic [35:0] set;
        if (rst) begin
            m_db = '0; m_chg = '0; m_ident = '0; m_edges = 0;
            for (int i = 0; i < ND; i++) begin
                m_run[i] = 0; m_amb[i] = 2'd0; m_blu[i] = 2'd0;
            end
            e_amber = OFFV; e_blue = OFFV; e_int = 1'b0; e_rd = 8'h00;
        end else begin
            ms = m_edges / CPM;
            for (int i = 0; i < ND; i++) begin
                e_amber[i] = (m_db[i] && lit(m_amb[i], ms)) ? ON : ~ON;
                e_blue[i]  = (m_db[i] && lit(m_ident[i] ? 2'd3 : m_blu[i], ms)) ? ON : ~ON;
            end
            e_int = |m_chg;
            a = int'(rd_addr);
            if (a < ND) e_rd = {2'b00, m_db[a], m_chg[a], m_amb[a], m_blu[a]};
            else        e_rd = 8'h00;
            set = '0;
            if (stb) begin
                for (int i = 0; i < ND; i++) begin
                    if (prsnt[i] == m_db[i]) begin
                        m_run[i] = 0;
                    end else begin
                        m_run[i]++;
                        if (m_run[i] == DBN) begin
                            m_db[i] = ~m_db[i]; m_run[i] = 0; set[i] = 1'b1;
                        end
                    end
                end
                m_ident = ident;
            end
            m_chg = (m_chg & ~chg_clr) | set;
            if (wr_en && int'(wr_addr) < ND) begin
                m_amb[wr_addr] = wr_data[3:2];
                m_blu[wr_addr] = wr_data[1:0];
            end
            m_edges++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stb = 1'b0; wr_en = 1'b0; chg_clr = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic sample(input logic [35:0] p, input logic [35:0] id);
        prsnt = p; ident = id; stb = 1'b1;
        step();
        stb = 1'b0;
    endtask

    task automatic write_mode(input logic [5:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (prsnt_db !== 36'h0) begin errors++; $display("FAIL reset_db: got %h want %h", prsnt_db, 36'h0); end
        checks++; if (prsnt_chg !== 36'h0) begin errors++; $display("FAIL reset_chg: got %h want %h", prsnt_chg, 36'h0); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_int: got %b want 0", irq); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd: got %h want 00", rd_data); end
        checks++; if (amber_dat !== OFFV) begin errors++; $display("FAIL reset_amber: got %h want %h", amber_dat, OFFV); end
        checks++; if (blue_dat !== OFFV) begin errors++; $display("FAIL reset_blue: got %h want %h", blue_dat, OFFV); end
        rst = 1'b0;
    endtask

    task automatic test_debounce_all();
        do_reset();
        sample(ALL1, '0);
        sample(ALL1, '0);
        checks++; if (prsnt_db !== 36'h0) begin errors++; $display("FAIL db_two_pulses: got %h want %h", prsnt_db, 36'h0); end
        do_reset();
        // Three back-to-back strobes, each one a separate sample.
        prsnt = ALL1; stb = 1'b1;
        step(); step(); step();
        stb = 1'b0;
        checks++; if (prsnt_db !== ALL1) begin errors++; $display("FAIL db_three_pulses: got %h want %h", prsnt_db, ALL1); end
        checks++; if (prsnt_chg !== ALL1) begin errors++; $display("FAIL chg_three_pulses: got %h want %h", prsnt_chg, ALL1); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL int_same_edge: got %b want 0", irq); end
        step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL int_next_edge: got %b want 1", irq); end
    endtask

    task automatic test_glitch();
        logic [35:0] p;
        logic        seq [6];
        seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        chg_clr = ALL1;
        step();
        chg_clr = '0;
        checks++; if (prsnt_chg !== 36'h0) begin errors++; $display("FAIL glitch_clear: got %h want 0", prsnt_chg); end
        for (int k = 0; k < 6; k++) begin
            p = ALL1; p[5] = seq[k];
            sample(p, '0);
            step();
            checks++; if (prsnt_db[5] !== (k != 5)) begin errors++; $display("FAIL glitch_db s%0d: got %b want %b", k, prsnt_db[5], k != 5); end
            checks++; if (prsnt_chg[5] !== (k == 5)) begin errors++; $display("FAIL glitch_chg s%0d: got %b want %b", k, prsnt_chg[5], k == 5); end
        end
        sample(p, '0);
        checks++; if (prsnt_chg !== 36'h20) begin errors++; $display("FAIL glitch_chg_once: got %h want %h", prsnt_chg, 36'h20); end
        checks++; if (prsnt_db !== (ALL1 & ~36'h20)) begin errors++; $display("FAIL glitch_others: got %h want %h", prsnt_db, ALL1 & ~36'h20); end
    endtask

    task automatic test_blink();
        int n_lit;
        do_reset();
        sample(ALL1, '0); sample(ALL1, '0); sample(ALL1, '0);
        write_mode(6'd0, 4'b1000);
        n_lit = 0;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (amber_dat[0] === ON) n_lit++;
            checks++; if (amber_dat[0] !== e_amber[0]) begin errors++; $display("FAIL slow_blink c%0d: got %b want %b", c, amber_dat[0], e_amber[0]); end
        end
        checks++; if (n_lit !== 2000) begin errors++; $display("FAIL slow_duty: got %0d want 2000", n_lit); end
        write_mode(6'd0, 4'b1100);
        n_lit = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (amber_dat[0] === ON) n_lit++;
            checks++; if (amber_dat[0] !== e_amber[0]) begin errors++; $display("FAIL fast_blink c%0d: got %b want %b", c, amber_dat[0], e_amber[0]); end
        end
        checks++; if (n_lit !== 500) begin errors++; $display("FAIL fast_duty: got %0d want 500", n_lit); end
        write_mode(6'd0, 4'b0100);
        for (int c = 0; c < 200; c++) begin
            step();
            checks++; if (amber_dat[0] !== ON) begin errors++; $display("FAIL solid_on c%0d: got %b want %b", c, amber_dat[0], ON); end
        end
        checks++; if (amber_dat[35:1] !== OFFV[35:1]) begin errors++; $display("FAIL amber_others: got %h want %h", amber_dat[35:1], OFFV[35:1]); end
    endtask

    task automatic test_ident();
        logic [35:0] id;
        logic [35:0] p;
        int n_lit;
        id = '0; id[7] = 1'b1;
        sample(ALL1, id);
        n_lit = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (blue_dat[7] === ON) n_lit++;
            checks++; if (blue_dat[7] !== e_blue[7]) begin errors++; $display("FAIL ident_blink c%0d: got %b want %b", c, blue_dat[7], e_blue[7]); end
        end
        checks++; if (n_lit !== 500) begin errors++; $display("FAIL ident_duty: got %0d want 500", n_lit); end
        p = ALL1; p[7] = 1'b0;
        sample(p, id); sample(p, id); sample(p, id);
        for (int c = 0; c < 300; c++) begin
            step();
            checks++; if (blue_dat[7] !== ~ON) begin errors++; $display("FAIL ident_absent c%0d: got %b want %b", c, blue_dat[7], ~ON); end
        end
    endtask

    task automatic test_registers();
        logic [35:0] p;
        for (int i = 0; i < ND; i++) write_mode(6'(i), 4'($urandom_range(0, 15)));
        write_mode(6'd36, 4'hF);
        write_mode(6'd63, 4'hF);
        for (int i = 0; i < ND; i++) begin
            rd_addr = 6'(i);
            step();
            checks++; if (rd_data !== e_rd) begin errors++; $display("FAIL readback d%0d: got %h want %h", i, rd_data, e_rd); end
        end
        rd_addr = 6'd40;
        step();
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rd_addr40: got %h want 00", rd_data); end
        rd_addr = 6'd0;
        chg_clr = ALL1;
        step();
        chg_clr = '0;
        p = ALL1; p[7] = 1'b0; p[3] = 1'b0;
        sample(p, '0); sample(p, '0);
        chg_clr[3] = 1'b1;
        sample(p, '0);
        chg_clr = '0;
        checks++; if (prsnt_chg[3] !== 1'b1) begin errors++; $display("FAIL chg_set_wins: got %b want 1", prsnt_chg[3]); end
        chg_clr[3] = 1'b1;
        step();
        chg_clr = '0;
        checks++; if (prsnt_chg[3] !== 1'b0) begin errors++; $display("FAIL chg_w1c: got %b want 0", prsnt_chg[3]); end
    endtask

    task automatic test_random();
        logic [35:0] target;
        target = rand36();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) target = rand36();
            stb = ($urandom_range(0, 2) == 0);
            prsnt = target ^ (rand36() & rand36() & rand36());
            ident = rand36();
            wr_en = ($urandom_range(0, 3) == 0);
            wr_addr = 6'($urandom_range(0, 63));
            wr_data = 4'($urandom_range(0, 15));
            rd_addr = 6'($urandom_range(0, 63));
            chg_clr = rand36() & rand36() & rand36();
            step();
            checks++; if (prsnt_db !== m_db) begin errors++; $display("FAIL rnd_db c%0d: got %h want %h", c, prsnt_db, m_db); end
            checks++; if (prsnt_chg !== m_chg) begin errors++; $display("FAIL rnd_chg c%0d: got %h want %h", c, prsnt_chg, m_chg); end
            checks++; if (irq !== e_int) begin errors++; $display("FAIL rnd_int c%0d: got %b want %b", c, irq, e_int); end
            checks++; if (rd_data !== e_rd) begin errors++; $display("FAIL rnd_rd c%0d: got %h want %h", c, rd_data, e_rd); end
            checks++; if (amber_dat !== e_amber) begin errors++; $display("FAIL rnd_amber c%0d: got %h want %h", c, amber_dat, e_amber); end
            checks++; if (blue_dat !== e_blue) begin errors++; $display("FAIL rnd_blue c%0d: got %h want %h", c, blue_dat, e_blue); end
        end
        rst = 1'b0; stb = 1'b0; wr_en = 1'b0; chg_clr = '0; rd_addr = '0;
    endtask

    task automatic test_reset_mid();
        logic [35:0] p;
        do_reset();
        sample(ALL1, '0); sample(ALL1, '0); sample(ALL1, '0);
        write_mode(6'd0, 4'b1110);
        for (int c = 0; c < 50; c++) step();
        p = ALL1; p[4] = 1'b0;
        sample(p, '0); sample(p, '0);
        rst = 1'b1;
        step();
        checks++; if (prsnt_db !== 36'h0) begin errors++; $display("FAIL mid_reset_db: got %h want 0", prsnt_db); end
        checks++; if (prsnt_chg !== 36'h0) begin errors++; $display("FAIL mid_reset_chg: got %h want 0", prsnt_chg); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_int: got %b want 0", irq); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_reset_rd: got %h want 00", rd_data); end
        checks++; if (amber_dat !== OFFV) begin errors++; $display("FAIL mid_reset_amber: got %h want %h", amber_dat, OFFV); end
        checks++; if (blue_dat !== OFFV) begin errors++; $display("FAIL mid_reset_blue: got %h want %h", blue_dat, OFFV); end
        rst = 1'b0;
        sample(ALL1, '0); sample(ALL1, '0);
        checks++; if (prsnt_db !== 36'h0) begin errors++; $display("FAIL mid_reset_restart: got %h want 0", prsnt_db); end
        sample(ALL1, '0);
        step();
        checks++; if (prsnt_db !== ALL1) begin errors++; $display("FAIL mid_reset_redb: got %h want %h", prsnt_db, ALL1); end
        checks++; if (amber_dat !== OFFV) begin errors++; $display("FAIL mid_reset_modes: got %h want %h", amber_dat, OFFV); end
    endtask

    initial begin
        test_reset();
        test_debounce_all();
        test_glitch();
        test_blink();
        test_ident();
        test_registers();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
